rv_ctrl_mc: RTL and testbench

Next-generation RV32 control unit for the pipelined core.
- Decodes the ID-stage instruction into the control bundle and registers it into the ID/EX stage, with stall and flush support.
- Adds optional M-extension decode.
- Runs a counter-based FSM that holds the pipeline while a multi-cycle MUL/DIV occupies EX.
- Sits between the ID-stage instruction fields and the EX datapath/muldiv unit; drives the IF/ID stall.

---
 rtl/rv_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_rv_ctrl_mc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_mc
// Purpose  : RV32I(+M) ID-stage decoder with ID/EX control register and MUL/DIV hold FSM.
//            Optional macro RV_CTRL_ILLEGAL_TRAP_EN enables illegal-instruction detection.
// Revision : 1.0 - initial release
// ============================================================================
module rv_ctrl_mc #(
  parameter int M_EN    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ctrl_valid,
  input  logic [6:0] i_ctrl_opcode,
  input  logic [2:0] i_ctrl_func3,
  input  logic [6:0] i_ctrl_func7,
  input  logic       i_ctrl_ex_stall,
  input  logic       i_ctrl_flush,
  output logic       o_ctrl_valid,
  output logic [2:0] o_ctrl_immext_ctrl,
  output logic       o_ctrl_is_branch,
  output logic       o_ctrl_is_jalr,
  output logic       o_ctrl_is_load,
  output logic [3:0] o_ctrl_alu_ctrl,
  output logic       o_ctrl_alu_a_sel,
  output logic       o_ctrl_alu_b_sel,
  output logic       o_ctrl_dmem_wen,
  output logic       o_ctrl_rf_wen,
  output logic [1:0] o_ctrl_rf_wdata_sel,
  output logic [2:0] o_ctrl_md_op,
  output logic       o_ctrl_md_start,
  output logic       o_ctrl_id_stall,
  output logic       o_ctrl_illegal
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  localparam logic [2:0] c_IMM_I = 3'd0;
  localparam logic [2:0] c_IMM_S = 3'd1;
  localparam logic [2:0] c_IMM_B = 3'd2;
  localparam logic [2:0] c_IMM_U = 3'd3;
  localparam logic [2:0] c_IMM_J = 3'd4;

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_SLL  = 4'd2;
  localparam logic [3:0] c_ALU_SLT  = 4'd3;
  localparam logic [3:0] c_ALU_SLTU = 4'd4;
  localparam logic [3:0] c_ALU_XOR  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_OR   = 4'd8;
  localparam logic [3:0] c_ALU_AND  = 4'd9;

  localparam logic [1:0] c_WB_ALU = 2'd0;
  localparam logic [1:0] c_WB_IMM = 2'd1;
  localparam logic [1:0] c_WB_PC4 = 2'd2;
  localparam logic [1:0] c_WB_MD  = 2'd3;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  // Counter preload is LAT-2 so that BUSY spans exactly LAT-1 cycles.
  localparam logic       c_MUL_MULTI = (MUL_LAT > 1);
  localparam logic       c_DIV_MULTI = (DIV_LAT > 1);
  localparam logic [5:0] c_MUL_CNT   = (MUL_LAT > 1) ? 6'(MUL_LAT - 2) : 6'd0;
  localparam logic [5:0] c_DIV_CNT   = (DIV_LAT > 1) ? 6'(DIV_LAT - 2) : 6'd0;

  function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'd0:    r = alt ? c_ALU_SUB : c_ALU_ADD;
      3'd1:    r = c_ALU_SLL;
      3'd2:    r = c_ALU_SLT;
      3'd3:    r = c_ALU_SLTU;
      3'd4:    r = c_ALU_XOR;
      3'd5:    r = alt ? c_ALU_SRA : c_ALU_SRL;
      3'd6:    r = c_ALU_OR;
      default: r = c_ALU_AND;
    endcase
    return r;
  endfunction

  logic       w_is_m;
  logic [2:0] w_immext;
  logic       w_br, w_jalr, w_ld, w_asel, w_bsel, w_dwen, w_rfwen;
  logic [3:0] w_alu;
  logic [1:0] w_wsel;
  logic       w_illegal;

  assign w_is_m = (M_EN != 0) && (i_ctrl_opcode == c_OP_OP) && (i_ctrl_func7 == 7'b0000001);

  always_comb begin
    w_immext = c_IMM_I;
    w_br     = 1'b0;
    w_jalr   = 1'b0;
    w_ld     = 1'b0;
    w_alu    = c_ALU_ADD;
    w_asel   = 1'b0;
    w_bsel   = 1'b0;
    w_dwen   = 1'b0;
    w_rfwen  = 1'b0;
    w_wsel   = c_WB_ALU;
    case (i_ctrl_opcode)
      c_OP_LUI:    begin w_immext = c_IMM_U; w_rfwen = 1'b1; w_wsel = c_WB_IMM; end
      c_OP_AUIPC:  begin w_immext = c_IMM_U; w_asel = 1'b1; w_rfwen = 1'b1; end
      c_OP_JAL:    begin w_immext = c_IMM_J; w_asel = 1'b1; w_rfwen = 1'b1; w_wsel = c_WB_PC4; end
      c_OP_JALR:   begin w_jalr = 1'b1; w_rfwen = 1'b1; w_wsel = c_WB_PC4; end
      c_OP_BRANCH: begin w_immext = c_IMM_B; w_br = 1'b1; w_asel = 1'b1; end
      c_OP_LOAD:   begin w_ld = 1'b1; w_rfwen = 1'b1; end
      c_OP_STORE:  begin w_immext = c_IMM_S; w_dwen = 1'b1; end
      c_OP_OPIMM: begin
        w_rfwen = 1'b1;
        // Immediate ADD has no SUB form; func7[5] only selects SRAI.
        w_alu   = f_alu(i_ctrl_func3, i_ctrl_func7[5] & (i_ctrl_func3 == 3'd5));
      end
      c_OP_OP: begin
        w_bsel  = 1'b1;
        w_rfwen = 1'b1;
        if (w_is_m) w_wsel = c_WB_MD;
        else        w_alu  = f_alu(i_ctrl_func3, i_ctrl_func7[5]);
      end
      default: ;
    endcase
  end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  always_comb begin
    w_illegal = 1'b0;
    case (i_ctrl_opcode)
      c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_OPIMM: w_illegal = 1'b0;
      c_OP_JALR:   w_illegal = (i_ctrl_func3 != 3'd0);
      c_OP_BRANCH: w_illegal = (i_ctrl_func3[2:1] == 2'b01);
      c_OP_LOAD:   w_illegal = (i_ctrl_func3 == 3'd3) || (i_ctrl_func3[2:1] == 2'b11);
      c_OP_STORE:  w_illegal = (i_ctrl_func3 > 3'd2);
      c_OP_OP:     w_illegal = !((i_ctrl_func7 == 7'd0) || (i_ctrl_func7 == 7'b0100000) || w_is_m)
                               || (i_ctrl_func7[5] && (i_ctrl_func3 != 3'd0) && (i_ctrl_func3 != 3'd5));
      default:     w_illegal = 1'b1;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  logic [0:0] r_state;
  logic [5:0] r_cnt;
  logic       w_cap_en, w_cap_valid, w_live, w_md_go, w_md_multi;
  logic [5:0] w_md_cnt;

  // Flush overrides both stall sources so the kill always lands.
  assign w_cap_en    = i_ctrl_flush | ~o_ctrl_id_stall;
  assign w_cap_valid = i_ctrl_valid & ~i_ctrl_flush;
  assign w_live      = w_cap_valid & ~w_illegal;
  assign w_md_go     = w_live & w_is_m;
  assign w_md_multi  = i_ctrl_func3[2] ? c_DIV_MULTI : c_MUL_MULTI;
  assign w_md_cnt    = i_ctrl_func3[2] ? c_DIV_CNT : c_MUL_CNT;

  logic       r_valid, r_br, r_jalr, r_ld, r_asel, r_bsel, r_dwen, r_rfwen, r_md_start;
  logic [2:0] r_immext, r_md_op;
  logic [3:0] r_alu;
  logic [1:0] r_wsel;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid    <= 1'b0;
      r_immext   <= 3'd0;
      r_br       <= 1'b0;
      r_jalr     <= 1'b0;
      r_ld       <= 1'b0;
      r_alu      <= 4'd0;
      r_asel     <= 1'b0;
      r_bsel     <= 1'b0;
      r_dwen     <= 1'b0;
      r_rfwen    <= 1'b0;
      r_wsel     <= 2'd0;
      r_md_op    <= 3'd0;
      r_md_start <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      if (w_cap_en) begin
        r_valid    <= w_cap_valid;
        r_immext   <= w_immext;
        r_br       <= w_br & w_live;
        r_jalr     <= w_jalr & w_live;
        r_ld       <= w_ld & w_live;
        r_alu      <= w_alu;
        r_asel     <= w_asel;
        r_bsel     <= w_bsel;
        r_dwen     <= w_dwen & w_live;
        r_rfwen    <= w_rfwen & w_live;
        r_wsel     <= w_wsel;
        r_md_op    <= w_is_m ? i_ctrl_func3 : 3'd0;
        r_md_start <= w_md_go;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 6'd0;
    end else if (i_ctrl_flush) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_cap_en && w_md_go && w_md_multi) begin
            r_state <= c_ST_BUSY;
            r_cnt   <= w_md_cnt;
          end
        end
        default: begin
          if (r_cnt == 6'd0) r_state <= c_ST_IDLE;
          else               r_cnt   <= r_cnt - 6'd1;
        end
      endcase
    end
  end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       r_illegal <= 1'b0;
    else if (w_cap_en) r_illegal <= w_cap_valid & w_illegal;
  end
  assign o_ctrl_illegal = r_illegal;
`else
  assign o_ctrl_illegal = 1'b0;
`endif

  assign o_ctrl_id_stall     = (r_state == c_ST_BUSY) | i_ctrl_ex_stall;
  assign o_ctrl_valid        = r_valid;
  assign o_ctrl_immext_ctrl  = r_immext;
  assign o_ctrl_is_branch    = r_br;
  assign o_ctrl_is_jalr      = r_jalr;
  assign o_ctrl_is_load      = r_ld;
  assign o_ctrl_alu_ctrl     = r_alu;
  assign o_ctrl_alu_a_sel    = r_asel;
  assign o_ctrl_alu_b_sel    = r_bsel;
  assign o_ctrl_dmem_wen     = r_dwen;
  assign o_ctrl_rf_wen       = r_rfwen;
  assign o_ctrl_rf_wdata_sel = r_wsel;
  assign o_ctrl_md_op        = r_md_op;
  assign o_ctrl_md_start     = r_md_start;

endmodule
`default_nettype wire

// File: tb/tb_rv_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_ctrl_mc
// Purpose  : Scoreboard bench for rv_ctrl_mc; three parameterisations share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_ctrl_mc;

  typedef struct packed {
    logic       valid;
    logic [2:0] immext;
    logic       br;
    logic       jalr;
    logic       ld;
    logic [3:0] alu;
    logic       asel;
    logic       bsel;
    logic       dwen;
    logic       rfwen;
    logic [1:0] wsel;
    logic [2:0] mdop;
    logic       mdstart;
    logic       idstall;
    logic       illegal;
  } bundle_t;

  localparam int P_MEN[3] = '{1, 1, 0};
  localparam int P_MUL[3] = '{2, 1, 2};
  localparam int P_DIV[3] = '{34, 3, 34};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       ex_stall = 1'b0;
  logic       flush = 1'b0;
  int         checks = 0;
  int         failures = 0;
  bundle_t    bund_a[3];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_of(input logic [2:0] a, input bit alt);
    case (a)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  // Reference: what the EX bundle becomes when this ID instruction is accepted.
  function automatic bundle_t model_capture(input logic v, input logic [6:0] o, input logic [2:0] a,
                                            input logic [6:0] b, input int men, input int mul,
                                            input int div, output int busy);
    bundle_t d;
    bit is_m, bad, ill, live, trap_en;
    d = '0; is_m = 0; bad = 0;
    case (o)
      7'b0110111: begin d.immext = 3; d.rfwen = 1; d.wsel = 1; end
      7'b0010111: begin d.immext = 3; d.asel = 1; d.rfwen = 1; end
      7'b1101111: begin d.immext = 4; d.asel = 1; d.rfwen = 1; d.wsel = 2; end
      7'b1100111: begin d.jalr = 1; d.rfwen = 1; d.wsel = 2; bad = (a != 0); end
      7'b1100011: begin d.immext = 2; d.br = 1; d.asel = 1; bad = (a == 2 || a == 3); end
      7'b0000011: begin d.ld = 1; d.rfwen = 1; bad = (a == 3 || a == 6 || a == 7); end
      7'b0100011: begin d.immext = 1; d.dwen = 1; bad = (a > 2); end
      7'b0010011: begin d.rfwen = 1; d.alu = alu_of(a, (a == 5) && b[5]); end
      7'b0110011: begin
        d.bsel = 1; d.rfwen = 1;
        if (men != 0 && b == 7'd1) begin
          is_m = 1; d.wsel = 3; d.mdop = a;
        end else begin
          d.alu = alu_of(a, b[5]);
          bad = !(b == 7'd0 || b == 7'h20) || (b[5] && !(a == 0 || a == 5));
        end
      end
      default: bad = 1;
    endcase
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    trap_en = 1;
`else
    trap_en = 0;
`endif
    ill  = bad && trap_en;
    live = v && !ill;
    d.valid   = v;
    d.illegal = v && ill;
    if (!live) begin d.br = 0; d.jalr = 0; d.ld = 0; d.dwen = 0; d.rfwen = 0; end
    d.mdstart = live && is_m;
    busy = d.mdstart ? ((a[2] ? div : mul) - 1) : 0;
    return d;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int MEN = P_MEN[k];
    localparam int MUL = P_MUL[k];
    localparam int DIV = P_DIV[k];
    logic       v, br, jalr, ld, asel, bsel, dwen, rfwen, mds, ids, ill;
    logic [2:0] imm, mdop;
    logic [3:0] alu;
    logic [1:0] wsel;
    bundle_t    got;
    bundle_t    exp_q[$];
    bundle_t    m_ex = '0;
    int         m_left = 0;

    rv_ctrl_mc #(.M_EN(MEN), .MUL_LAT(MUL), .DIV_LAT(DIV)) u_dut (
      .i_clk(clk), .i_rstn(rst_n), .i_ctrl_valid(in_valid), .i_ctrl_opcode(op),
      .i_ctrl_func3(f3), .i_ctrl_func7(f7), .i_ctrl_ex_stall(ex_stall), .i_ctrl_flush(flush),
      .o_ctrl_valid(v), .o_ctrl_immext_ctrl(imm), .o_ctrl_is_branch(br), .o_ctrl_is_jalr(jalr),
      .o_ctrl_is_load(ld), .o_ctrl_alu_ctrl(alu), .o_ctrl_alu_a_sel(asel), .o_ctrl_alu_b_sel(bsel),
      .o_ctrl_dmem_wen(dwen), .o_ctrl_rf_wen(rfwen), .o_ctrl_rf_wdata_sel(wsel),
      .o_ctrl_md_op(mdop), .o_ctrl_md_start(mds), .o_ctrl_id_stall(ids), .o_ctrl_illegal(ill)
    );

    assign got = {v, imm, br, jalr, ld, alu, asel, bsel, dwen, rfwen, wsel, mdop, mds, ids, ill};
    assign bund_a[k] = got;

    // m_left counts the remaining cycles during which the M instruction still holds EX.
    always @(posedge clk) begin : model
      bundle_t e;
      int      busy;
      if (!rst_n) begin
        m_ex = '0; m_left = 0;
      end else if (flush || (m_left == 0 && !ex_stall)) begin
        m_ex = model_capture(in_valid && !flush, op, f3, f7, MEN, MUL, DIV, busy);
        m_left = flush ? 0 : busy;
      end else begin
        m_ex.mdstart = 1'b0;
        if (m_left > 0) m_left--;
      end
      e = m_ex;
      e.idstall = (m_left > 0) || ex_stall;
      exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor
      bundle_t e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty dut%0d t=%0t got=%h required=entry", k, $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL bundle dut%0d t=%0t got=%h required=%h", k, $time, got, e);
        end
      end
    end
  end

  task automatic drv(input logic vv, input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                     input logic xs, input logic fl);
    @(negedge clk);
    in_valid = vv; op = o; f3 = a; f7 = b; ex_stall = xs; flush = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bund_a[k] !== '0) begin
        failures++;
        $display("FAIL async_reset dut%0d got=%h required=0", k, bund_a[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 12))
      0: return 7'b0110111;
      1: return 7'b0010111;
      2: return 7'b1101111;
      3: return 7'b1100111;
      4: return 7'b1100011;
      5: return 7'b0000011;
      6: return 7'b0100011;
      7: return 7'b0010011;
      8, 9, 10: return 7'b0110011;
      11: return 7'b0000000;
      default: return 7'($urandom);
    endcase
  endfunction

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;

  initial begin
    logic [6:0] ro;
    logic [6:0] rf7;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drv(1, OPI, 3'd0, 7'd0, 0, 0);            // ADDI
    drv(1, OPR, 3'd0, 7'h20, 0, 0);           // SUB
    drv(1, 7'b0100011, 3'd2, 7'd0, 0, 0);     // SW
    drv(1, OPR, 3'd0, 7'd1, 0, 0);            // MUL
    repeat (3) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, OPR, 3'd4, 7'd1, 0, 0);            // DIV, full latency
    repeat (40) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, OPR, 3'd4, 7'd1, 0, 0);            // DIV, flushed while stalling
    repeat (10) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, OPI, 3'd0, 7'd0, 0, 1);
    repeat (3) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, 7'b1100011, 3'd0, 7'd0, 0, 0);     // BEQ then MEM stall
    repeat (3) drv(1, OPI, 3'd0, 7'd0, 1, 0);
    drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, 7'b0000000, 3'd0, 7'd0, 0, 0);     // unknown opcode
    drv(1, OPR, 3'd0, 7'd1, 0, 0);            // M encoding (illegal where M_EN=0)
    repeat (3) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    drv(1, OPR, 3'd4, 7'd1, 0, 0);            // DIV then reset while busy
    repeat (4) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    do_reset();
    drv(1, OPR, 3'd1, 7'd1, 0, 0);            // MULH back-to-back with DIVU
    drv(1, OPR, 3'd5, 7'd1, 0, 0);
    repeat (40) drv(1, OPI, 3'd0, 7'd0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      ro = rand_op();
      case ($urandom_range(0, 3))
        0: rf7 = 7'd0;
        1: rf7 = 7'h20;
        2: rf7 = 7'd1;
        default: rf7 = 7'($urandom);
      endcase
      drv($urandom_range(0, 9) != 0, ro, 3'($urandom), rf7,
          $urandom_range(0, 11) == 0, $urandom_range(0, 24) == 0);
    end
    repeat (3) drv(0, OPI, 3'd0, 7'd0, 0, 0);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
